// File: rtl/matmul_job_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : matmul_job_sequencer
// Purpose  : Walks a 64-bit descriptor program and issues jobs to the ternary
//            matmul engine. Define MATMUL_SEQ_PERF_EN to add perf counters.
// Revision : 1.0
// ============================================================================
module matmul_job_sequencer #(
    parameter int ACK_TIMEOUT = 1024,
    parameter int RST_CYCLES  = 8,
    parameter int PGM_AW      = 6
) (
    input  logic              clk_clk,
    input  logic              reset_reset,
    input  logic              ctrl_go,
    input  logic              ctrl_abort,
    input  logic [PGM_AW-1:0] ctrl_first_pc,
    output logic [PGM_AW-1:0] pgm_address,
    output logic              pgm_chipselect,
    output logic              pgm_clken,
    input  logic [63:0]       pgm_readdata,
    output logic [31:0]       matmul_start_export,
    input  logic [31:0]       matmul_ready_export,
    output logic              matmul_reset_reset,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [1:0]        err_code,
    output logic [15:0]       jobs_done,
    output logic [PGM_AW-1:0] cur_pc
`ifdef MATMUL_SEQ_PERF_EN
    ,
    output logic [31:0]       perf_busy_cycles,
    output logic [31:0]       perf_wait_cycles
`endif
);

    localparam logic [1:0] C_OP_NOP   = 2'b00;
    localparam logic [1:0] C_OP_RUN   = 2'b01;
    localparam logic [1:0] C_OP_RESET = 2'b10;
    localparam logic [1:0] C_OP_END   = 2'b11;

    localparam logic [1:0] C_ERR_TIMEOUT = 2'b01;
    localparam logic [1:0] C_ERR_NOTIDLE = 2'b10;
    localparam logic [1:0] C_ERR_WRAP    = 2'b11;

    localparam int C_CNT_MAX = (ACK_TIMEOUT > RST_CYCLES) ? ACK_TIMEOUT : RST_CYCLES;
    localparam int C_CNT_W   = $clog2(C_CNT_MAX + 1);
    localparam logic [C_CNT_W-1:0] C_ACK_LAST = C_CNT_W'(ACK_TIMEOUT - 1);
    localparam logic [C_CNT_W-1:0] C_RST_LAST = C_CNT_W'(RST_CYCLES - 1);

    typedef enum logic [3:0] {
        S_IDLE      = 4'd0,
        S_FETCH     = 4'd1,
        S_DECODE    = 4'd2,
        S_ISSUE     = 4'd3,
        S_WAIT_ACK  = 4'd4,
        S_WAIT_DONE = 4'd5,
        S_RST_ENG   = 4'd6,
        S_HALT_OK   = 4'd7,
        S_HALT_ERR  = 4'd8
    } state_t;

    state_t              r_state, w_state_nxt;
    logic [PGM_AW-1:0]   r_pc, w_pc_nxt;
    logic [C_CNT_W-1:0]  r_cnt, w_cnt_nxt;
    logic [31:0]         r_job, w_job_nxt;
    logic                r_busy, w_busy_nxt;
    logic                r_done, w_done_nxt;
    logic                r_error, w_error_nxt;
    logic [1:0]          r_err_code, w_err_code_nxt;
    logic [15:0]         r_jobs_done, w_jobs_nxt;
    logic                r_eng_rst;
    logic                w_adv;
    logic                w_ready;
    logic                w_go_accept;
    logic                w_unused_bits;

    assign w_ready     = matmul_ready_export[0];
    assign w_go_accept = (r_state == S_IDLE) && ctrl_go && !ctrl_abort;
    assign w_unused_bits = &{1'b0, pgm_readdata[61:32], matmul_ready_export[31:1]};

    always_comb begin
        w_state_nxt    = r_state;
        w_pc_nxt       = r_pc;
        w_cnt_nxt      = r_cnt;
        w_job_nxt      = r_job;
        w_busy_nxt     = r_busy;
        w_done_nxt     = r_done;
        w_error_nxt    = r_error;
        w_err_code_nxt = r_err_code;
        w_jobs_nxt     = r_jobs_done;
        w_adv          = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (w_go_accept) begin
                    w_pc_nxt       = ctrl_first_pc;
                    w_done_nxt     = 1'b0;
                    w_error_nxt    = 1'b0;
                    w_err_code_nxt = 2'b00;
                    w_jobs_nxt     = 16'd0;
                    w_busy_nxt     = 1'b1;
                    w_state_nxt    = S_FETCH;
                end
            end
            S_FETCH: w_state_nxt = S_DECODE;
            S_DECODE: begin
                w_cnt_nxt = '0;
                w_job_nxt = pgm_readdata[31:0];
                case (pgm_readdata[63:62])
                    C_OP_NOP:   w_adv = 1'b1;
                    C_OP_RUN: begin
                        // A zero job word would never be visible to the engine
                        if (pgm_readdata[31:0] == 32'd0) w_adv = 1'b1;
                        else                             w_state_nxt = S_ISSUE;
                    end
                    C_OP_RESET: w_state_nxt = S_RST_ENG;
                    C_OP_END:   w_state_nxt = S_HALT_OK;
                endcase
            end
            S_ISSUE: begin
                w_cnt_nxt = '0;
                if (!w_ready) begin
                    w_err_code_nxt = C_ERR_NOTIDLE;
                    w_state_nxt    = S_HALT_ERR;
                end else begin
                    w_state_nxt = S_WAIT_ACK;
                end
            end
            S_WAIT_ACK: begin
                if (!w_ready) begin
                    w_state_nxt = S_WAIT_DONE;
                end else if (r_cnt == C_ACK_LAST) begin
                    w_err_code_nxt = C_ERR_TIMEOUT;
                    w_state_nxt    = S_HALT_ERR;
                end else begin
                    w_cnt_nxt = r_cnt + C_CNT_W'(1);
                end
            end
            S_WAIT_DONE: begin
                if (w_ready) begin
                    if (r_jobs_done != 16'hFFFF) w_jobs_nxt = r_jobs_done + 16'd1;
                    w_adv = 1'b1;
                end
            end
            S_RST_ENG: begin
                if (r_cnt == C_RST_LAST) w_adv = 1'b1;
                else                     w_cnt_nxt = r_cnt + C_CNT_W'(1);
            end
            S_HALT_OK: begin
                w_done_nxt  = 1'b1;
                w_busy_nxt  = 1'b0;
                w_state_nxt = S_IDLE;
            end
            S_HALT_ERR: begin
                w_error_nxt = 1'b1;
                w_busy_nxt  = 1'b0;
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_busy_nxt  = 1'b0;
                w_state_nxt = S_IDLE;
            end
        endcase

        // Falling off the end of program RAM is a fault, never a silent wrap
        if (w_adv) begin
            if (r_pc == {PGM_AW{1'b1}}) begin
                w_err_code_nxt = C_ERR_WRAP;
                w_state_nxt    = S_HALT_ERR;
            end else begin
                w_pc_nxt    = r_pc + PGM_AW'(1);
                w_state_nxt = S_FETCH;
            end
        end

        if (ctrl_abort && (r_state != S_IDLE) && (r_state != S_HALT_OK) &&
            (r_state != S_HALT_ERR)) begin
            w_state_nxt    = S_IDLE;
            w_busy_nxt     = 1'b0;
            w_pc_nxt       = r_pc;
            w_err_code_nxt = r_err_code;
            w_jobs_nxt     = r_jobs_done;
        end
    end

    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            r_state     <= S_IDLE;
            r_pc        <= '0;
            r_cnt       <= '0;
            r_job       <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_error     <= 1'b0;
            r_err_code  <= 2'b00;
            r_jobs_done <= 16'd0;
            r_eng_rst   <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_pc        <= w_pc_nxt;
            r_cnt       <= w_cnt_nxt;
            r_job       <= w_job_nxt;
            r_busy      <= w_busy_nxt;
            r_done      <= w_done_nxt;
            r_error     <= w_error_nxt;
            r_err_code  <= w_err_code_nxt;
            r_jobs_done <= w_jobs_nxt;
            // Registered so the engine reset is glitch-free and tracks RST_ENG exactly
            r_eng_rst   <= (w_state_nxt == S_RST_ENG);
        end
    end

    assign pgm_address         = r_pc;
    assign pgm_chipselect      = (r_state == S_FETCH);
    assign pgm_clken           = (r_state == S_FETCH);
    assign matmul_start_export = ((r_state == S_ISSUE) && w_ready) ? r_job : 32'd0;
    assign matmul_reset_reset  = r_eng_rst;
    assign busy                = r_busy;
    assign done                = r_done;
    assign error               = r_error;
    assign err_code            = r_err_code;
    assign jobs_done           = r_jobs_done;
    assign cur_pc              = r_pc;

`ifdef MATMUL_SEQ_PERF_EN
    logic [31:0] r_perf_busy;
    logic [31:0] r_perf_wait;

    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            r_perf_busy <= 32'd0;
            r_perf_wait <= 32'd0;
        end else if (w_go_accept) begin
            r_perf_busy <= 32'd0;
            r_perf_wait <= 32'd0;
        end else begin
            if (r_busy && (r_perf_busy != 32'hFFFF_FFFF))
                r_perf_busy <= r_perf_busy + 32'd1;
            if ((r_state == S_WAIT_DONE) && (r_perf_wait != 32'hFFFF_FFFF))
                r_perf_wait <= r_perf_wait + 32'd1;
        end
    end

    assign perf_busy_cycles = r_perf_busy;
    assign perf_wait_cycles = r_perf_wait;
`endif

endmodule
`default_nettype wire

// File: tb/tb_matmul_job_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_matmul_job_sequencer
// Purpose  : Randomized program/engine stimulus against a descriptor-level
//            reference model, plus directed abort and reset cases.
// Revision : 1.0
// ============================================================================
module tb_matmul_job_sequencer;

    localparam int C_RST_CYCLES = 8;

    logic        clk_clk = 1'b0;
    logic        reset_reset = 1'b1;
    logic        ctrl_go = 1'b0;
    logic        ctrl_abort = 1'b0;
    logic [5:0]  ctrl_first_pc = 6'd0;
    logic [5:0]  pgm_address;
    logic        pgm_chipselect;
    logic        pgm_clken;
    logic [63:0] pgm_readdata = 64'd0;
    logic [31:0] matmul_start_export;
    logic [31:0] matmul_ready_export;
    logic        matmul_reset_reset;
    logic        busy, done, error;
    logic [1:0]  err_code;
    logic [15:0] jobs_done;
    logic [5:0]  cur_pc;
`ifdef MATMUL_SEQ_PERF_EN
    logic [31:0] perf_busy_cycles;
    logic [31:0] perf_wait_cycles;
`endif

    always #5 clk_clk = ~clk_clk;

    matmul_job_sequencer dut (
        .clk_clk             (clk_clk),
        .reset_reset         (reset_reset),
        .ctrl_go             (ctrl_go),
        .ctrl_abort          (ctrl_abort),
        .ctrl_first_pc       (ctrl_first_pc),
        .pgm_address         (pgm_address),
        .pgm_chipselect      (pgm_chipselect),
        .pgm_clken           (pgm_clken),
        .pgm_readdata        (pgm_readdata),
        .matmul_start_export (matmul_start_export),
        .matmul_ready_export (matmul_ready_export),
        .matmul_reset_reset  (matmul_reset_reset),
        .busy                (busy),
        .done                (done),
        .error               (error),
        .err_code            (err_code),
        .jobs_done           (jobs_done),
        .cur_pc              (cur_pc)
`ifdef MATMUL_SEQ_PERF_EN
        ,
        .perf_busy_cycles    (perf_busy_cycles),
        .perf_wait_cycles    (perf_wait_cycles)
`endif
    );

    // Program RAM: one-cycle registered read
    logic [63:0] pgm [64];
    always @(posedge clk_clk)
        if (pgm_chipselect && pgm_clken) pgm_readdata <= pgm[pgm_address];

    // Engine: mode 0 acks after drop_dly and finishes after done_dly,
    // mode 1 never acks, mode 2 is never idle
    int   eng_mode = 0, drop_dly = 3, done_dly = 20;
    int   eng_phase = 0, eng_cnt = 0;
    logic eng_rdy = 1'b1;
    assign matmul_ready_export = {31'h2A5A_5A5A, eng_rdy};

    always @(posedge clk_clk) begin
        case (eng_mode)
            1: eng_rdy <= 1'b1;
            2: eng_rdy <= 1'b0;
            default: begin
                if (eng_phase == 0) begin
                    eng_rdy <= 1'b1;
                    if (matmul_start_export != 32'd0) begin
                        eng_phase <= 1;
                        eng_cnt   <= drop_dly;
                    end
                end else if (eng_phase == 1) begin
                    if (eng_cnt <= 1) begin
                        eng_rdy   <= 1'b0;
                        eng_phase <= 2;
                        eng_cnt   <= done_dly;
                    end else eng_cnt <= eng_cnt - 1;
                end else begin
                    if (eng_cnt <= 1) begin
                        eng_rdy   <= 1'b1;
                        eng_phase <= 0;
                    end else eng_cnt <= eng_cnt - 1;
                end
            end
        endcase
    end

    // Monitors: observed start pulses and engine-reset pulse widths
    logic [31:0] got_starts[$];
    int          got_pulses[$];
    int          rst_run = 0;
    logic        prev_start_nz = 1'b0;
    int          dbl_start = 0;

    always @(negedge clk_clk) begin
        if (matmul_start_export != 32'd0) begin
            got_starts.push_back(matmul_start_export);
            if (prev_start_nz) dbl_start++;
        end
        prev_start_nz = (matmul_start_export != 32'd0);
        if (matmul_reset_reset) rst_run++;
        else if (rst_run > 0) begin
            got_pulses.push_back(rst_run);
            rst_run = 0;
        end
    end

    int n_vec = 0, n_err = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] pack(input logic [1:0] op, input logic [31:0] job);
        logic [29:0] rsv;
        rsv = 30'($urandom);
        return {op, rsv, job};
    endfunction

    task automatic fill_random();
        int r;
        logic [1:0] op;
        logic [31:0] job;
        for (int i = 0; i < 64; i++) begin
            r   = $urandom_range(0, 99);
            op  = (r < 25) ? 2'd0 : (r < 70) ? 2'd1 : (r < 80) ? 2'd2 : 2'd3;
            job = ($urandom_range(0, 9) == 0) ? 32'd0 : 32'($urandom);
            pgm[i] = pack(op, job);
        end
    endtask

    // Reference model: walk the descriptor list by the descriptor rules
    logic [31:0] exp_starts[$];
    int          exp_resets, exp_jobs, exp_pc;
    logic        exp_done, exp_error;
    logic [1:0]  exp_code;

    task automatic model(input int first, input int mode);
        int pc;
        bit fin, adv;
        logic [63:0] d;
        pc = first; fin = 0;
        exp_starts.delete();
        exp_resets = 0; exp_jobs = 0; exp_done = 0; exp_error = 0; exp_code = 2'd0;
        while (!fin) begin
            d = pgm[pc];
            adv = 0;
            case (d[63:62])
                2'd0: adv = 1;
                2'd1: begin
                    if (d[31:0] == 32'd0) adv = 1;
                    else if (mode == 2) begin
                        exp_error = 1; exp_code = 2'd2; fin = 1;
                    end else begin
                        exp_starts.push_back(d[31:0]);
                        if (mode == 1) begin
                            exp_error = 1; exp_code = 2'd1; fin = 1;
                        end else begin
                            exp_jobs++; adv = 1;
                        end
                    end
                end
                2'd2: begin exp_resets++; adv = 1; end
                default: begin exp_done = 1; fin = 1; end
            endcase
            if (adv) begin
                if (pc == 63) begin
                    exp_error = 1; exp_code = 2'd3; fin = 1;
                end else pc++;
            end
        end
        exp_pc = pc;
    endtask

    task automatic run_prog(input int first, input int mode, input int da, input int dd,
                            input string tag);
        int cyc;
        model(first, mode);
        got_starts.delete();
        got_pulses.delete();
        dbl_start = 0;
        eng_mode = mode; drop_dly = da; done_dly = dd;
        @(negedge clk_clk);
        ctrl_first_pc = 6'(first);
        ctrl_go = 1'b1;
        @(negedge clk_clk);
        ctrl_go = 1'b0;
        ctrl_first_pc = 6'($urandom);
        cyc = 0;
        while (!(done || error) && cyc < 8000) begin
            @(negedge clk_clk);
            cyc++;
        end
        chk({tag, ".halted"}, 64'(done | error), 64'(1));
`ifdef MATMUL_SEQ_PERF_EN
        chk({tag, ".perf_busy"}, 64'(perf_busy_cycles), 64'(cyc));
`endif
        @(negedge clk_clk);
        chk({tag, ".done"},     64'(done),      64'(exp_done));
        chk({tag, ".error"},    64'(error),     64'(exp_error));
        chk({tag, ".err_code"}, 64'(err_code),  64'(exp_code));
        chk({tag, ".jobs"},     64'(jobs_done), 64'(exp_jobs));
        chk({tag, ".busy"},     64'(busy),      64'(0));
        chk({tag, ".cur_pc"},   64'(cur_pc),    64'(exp_pc));
        chk({tag, ".nstart"},   64'(got_starts.size()), 64'(exp_starts.size()));
        for (int i = 0; i < got_starts.size() && i < exp_starts.size(); i++)
            chk({tag, ".start"}, 64'(got_starts[i]), 64'(exp_starts[i]));
        chk({tag, ".start_1cyc"}, 64'(dbl_start), 64'(0));
        chk({tag, ".npulse"}, 64'(got_pulses.size()), 64'(exp_resets));
        foreach (got_pulses[i])
            chk({tag, ".pulse_w"}, 64'(got_pulses[i]), 64'(C_RST_CYCLES));
    endtask

    task automatic wait_ready(input logic lvl, input string tag);
        int n;
        n = 0;
        while (eng_rdy != lvl && n < 200) begin
            @(negedge clk_clk);
            n++;
        end
        chk(tag, 64'(eng_rdy), 64'(lvl));
    endtask

    initial begin
        int mode, first;
        fill_random();
        repeat (3) @(negedge clk_clk);
        chk("rst.busy",  64'(busy),      64'(0));
        chk("rst.done",  64'(done),      64'(0));
        chk("rst.error", 64'(error),     64'(0));
        chk("rst.code",  64'(err_code),  64'(0));
        chk("rst.jobs",  64'(jobs_done), 64'(0));
        chk("rst.pc",    64'(cur_pc),    64'(0));
        chk("rst.start", 64'(matmul_start_export), 64'(0));
        chk("rst.engrst", 64'(matmul_reset_reset), 64'(0));
        chk("rst.cs",    64'(pgm_chipselect), 64'(0));
        reset_reset = 1'b0;

        pgm[0] = pack(2'd1, 32'h5);
        pgm[1] = pack(2'd1, 32'h7);
        pgm[2] = pack(2'd3, 32'h0);
        run_prog(0, 0, 3, 20, "run2");

        pgm[10] = pack(2'd2, 32'h0);
        pgm[11] = pack(2'd3, 32'h0);
        run_prog(10, 0, 3, 20, "reset");

        pgm[0] = pack(2'd1, 32'h1234);
        run_prog(0, 1, 3, 20, "timeout");

        pgm[63] = pack(2'd0, 32'h0);
        run_prog(63, 0, 3, 20, "wrap");

        pgm[4] = pack(2'd1, 32'hAB);
        run_prog(4, 2, 3, 20, "notidle");

        // Abort during WAIT_DONE, then restart from a different first pc
        pgm[0] = pack(2'd1, 32'h5);
        pgm[1] = pack(2'd3, 32'h0);
        eng_mode = 0; drop_dly = 2; done_dly = 30;
        @(negedge clk_clk);
        ctrl_first_pc = 6'd0; ctrl_go = 1'b1;
        @(negedge clk_clk);
        ctrl_go = 1'b0;
        wait_ready(1'b0, "abort.ack");
        repeat (3) @(negedge clk_clk);
        ctrl_abort = 1'b1;
        @(negedge clk_clk);
        ctrl_abort = 1'b0;
        chk("abort.busy",  64'(busy),  64'(0));
        chk("abort.done",  64'(done),  64'(0));
        chk("abort.error", 64'(error), 64'(0));
        chk("abort.jobs",  64'(jobs_done), 64'(0));
        chk("abort.start", 64'(matmul_start_export), 64'(0));
        @(negedge clk_clk);
        chk("abort.idle_cs", 64'(pgm_chipselect), 64'(0));
        wait_ready(1'b1, "abort.engidle");
        pgm[20] = pack(2'd1, 32'h9);
        pgm[21] = pack(2'd3, 32'h0);
        run_prog(20, 0, 3, 10, "restart");

        // Abort mid engine reset
        pgm[5] = pack(2'd2, 32'h0);
        pgm[6] = pack(2'd3, 32'h0);
        @(negedge clk_clk);
        ctrl_first_pc = 6'd5; ctrl_go = 1'b1;
        @(negedge clk_clk);
        ctrl_go = 1'b0;
        repeat (4) @(negedge clk_clk);
        chk("rabort.engrst_on", 64'(matmul_reset_reset), 64'(1));
        ctrl_abort = 1'b1;
        @(negedge clk_clk);
        ctrl_abort = 1'b0;
        chk("rabort.engrst_off", 64'(matmul_reset_reset), 64'(0));
        chk("rabort.busy", 64'(busy), 64'(0));

        // go and abort together in IDLE: abort wins
        @(negedge clk_clk);
        ctrl_go = 1'b1; ctrl_abort = 1'b1;
        @(negedge clk_clk);
        ctrl_go = 1'b0; ctrl_abort = 1'b0;
        chk("goabort.busy", 64'(busy), 64'(0));
        @(negedge clk_clk);
        chk("goabort.cs", 64'(pgm_chipselect), 64'(0));

        for (int t = 0; t < 40; t++) begin
            fill_random();
            mode  = $urandom_range(0, 19);
            mode  = (mode == 0) ? 1 : (mode == 1) ? 2 : 0;
            first = ($urandom_range(0, 3) == 0) ? $urandom_range(56, 63) : $urandom_range(0, 63);
            run_prog(first, mode, $urandom_range(1, 6), $urandom_range(1, 25), "rand");
        end

        // Asynchronous reset in the middle of an engine reset pulse
        pgm[7] = pack(2'd2, 32'h0);
        pgm[8] = pack(2'd3, 32'h0);
        eng_mode = 0;
        @(negedge clk_clk);
        ctrl_first_pc = 6'd7; ctrl_go = 1'b1;
        @(negedge clk_clk);
        ctrl_go = 1'b0;
        repeat (4) @(negedge clk_clk);
        chk("arst.engrst_on", 64'(matmul_reset_reset), 64'(1));
        @(posedge clk_clk);
        #2 reset_reset = 1'b1;
        #1;
        chk("arst.engrst_off", 64'(matmul_reset_reset), 64'(0));
        chk("arst.busy", 64'(busy), 64'(0));
        @(negedge clk_clk);
        reset_reset = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/matmul_job_sequencer.md
Name: matmul_job_sequencer

Overview:
- Autonomous job sequencer for the ternary matmul engine.
- Walks a descriptor program held in the 64 x 64-bit matmul program RAM, issues each job on the matmul start export, and handshakes completion on the ready export.
- Pulses the engine's reset when a descriptor asks for it.
- Sits in the matmul clock domain between the MMIO control CSRs and the engine, replacing host-driven start/ready polling.

Parameters:
- ACK_TIMEOUT, 1024: max cycles from start issue to engine ack (ready[0] low) before error.
- RST_CYCLES, 8: width in cycles of the engine reset pulse for a RESET descriptor.
- PGM_AW, 6: program RAM address width (64 descriptors).

Ports:
- clk_clk  in  1  matmul clock
- reset_reset  in  1  asynchronous active-high reset
- ctrl_go  in  1  one-cycle pulse: start program at ctrl_first_pc
- ctrl_abort  in  1  level: abandon program, return to IDLE
- ctrl_first_pc  in  PGM_AW  first descriptor index
- pgm_address  out  PGM_AW  program RAM address
- pgm_chipselect  out  1  program RAM select
- pgm_clken  out  1  program RAM clock enable
- pgm_readdata  in  64  descriptor word, valid 1 cycle after address
- matmul_start_export  out  32  job word to engine; nonzero for exactly one cycle per job
- matmul_ready_export  in  32  engine status; bit0 = idle/done, others ignored
- matmul_reset_reset  out  1  engine reset, active high
- busy  out  1  program running
- done  out  1  sticky: program reached END
- error  out  1  sticky: program halted on fault
- err_code  out  2  01 ack timeout, 10 engine not idle at issue, 11 PC wrap
- jobs_done  out  16  RUN descriptors completed this program
- cur_pc  out  PGM_AW  index of descriptor being executed

Behaviour:
- Reset values: all outputs 0, state IDLE.
- Descriptor format:
  - [63:62] opcode: 00 NOP, 01 RUN, 10 RESET, 11 END.
  - [31:0] job word for RUN. A RUN with job word 0 is treated as NOP.
  - Other bits reserved and ignored.
- States: IDLE, FETCH, DECODE, ISSUE, WAIT_ACK, WAIT_DONE, RST_ENG, HALT_OK, HALT_ERR.
- IDLE:
  - On ctrl_go: clear done/error/err_code/jobs_done, set pc = ctrl_first_pc, busy = 1, go to FETCH.
  - ctrl_go in any other state is ignored.
- FETCH: drive pgm_address = pc with chipselect = clken = 1 for one cycle, then go to DECODE. Read latency is exactly 1 cycle.
- DECODE (readdata valid):
  - NOP: pc++, go to FETCH.
  - RUN: go to ISSUE.
  - RESET: go to RST_ENG.
  - END: go to HALT_OK.
- ISSUE:
  - If ready[0] = 0: error, err_code = 10, go to HALT_ERR.
  - Otherwise drive matmul_start_export = job word for this single cycle, reset the timeout counter, go to WAIT_ACK.
- WAIT_ACK:
  - ready[0] = 0: go to WAIT_DONE.
  - Counter reaches ACK_TIMEOUT with ready[0] still 1: err_code = 01, go to HALT_ERR.
- WAIT_DONE: on ready[0] = 1, jobs_done++ (saturate at 0xFFFF), pc++, go to FETCH. No timeout in this state.
- RST_ENG: matmul_reset_reset high for exactly RST_CYCLES cycles, then pc++, go to FETCH.
- PC wrap: incrementing pc past 2^PGM_AW-1 sets err_code = 11 and goes to HALT_ERR (no silent wrap).
- HALT_OK: done = 1, busy = 0, go to IDLE.
- HALT_ERR: error = 1, busy = 0, go to IDLE.
- done/error hold until the next accepted ctrl_go.
- ctrl_abort (any non-IDLE state):
  - Next cycle: go to IDLE, busy = 0, start_export = 0.
  - If abort occurs mid-RST_ENG, engine reset deasserts.
  - done/error unchanged, jobs_done retained.
- ctrl_go and ctrl_abort together in IDLE: abort wins, go ignored.
- cur_pc is valid whenever busy = 1.
- start_export is 0 in every state except ISSUE.
- Asynchronous reset mid-program: all state cleared at once, engine reset output deasserted.

Optional Feature:
- Macro MATMUL_SEQ_PERF_EN.
- When defined:
  - Adds output perf_busy_cycles (32): counts cycles with busy = 1, cleared on accepted ctrl_go, saturating.
  - Adds output perf_wait_cycles (32): counts cycles in WAIT_DONE, cleared on accepted ctrl_go, saturating.
- When undefined: ports absent, no counters synthesized.

Test Plan:
- Program [RUN 0x00000005, RUN 0x00000007, END] at pc 0; engine model drops ready 3 cycles after start and raises it 20 cycles later.
  - Expect two one-cycle start pulses with values 5 and 7.
  - Expect jobs_done = 2, done = 1, error = 0, busy = 0.
- Program [RESET, END] with RST_CYCLES = 8 -> matmul_reset_reset high exactly 8 consecutive cycles, then done = 1, jobs_done = 0.
- RUN issued with engine ready[0] held at 1 forever -> after 1024 cycles in WAIT_ACK: error = 1, err_code = 01, cur_pc = 0.
- ctrl_first_pc = 63 with a NOP at 63 -> pc increment past 63 gives error = 1, err_code = 11; start_export never nonzero.
- ctrl_abort asserted during WAIT_DONE -> next cycle busy = 0, state IDLE, done = error = 0; a subsequent ctrl_go restarts from ctrl_first_pc.
- RUN reached with ready[0] = 0 at ISSUE -> err_code = 10, no start pulse.
- With MATMUL_SEQ_PERF_EN: perf_busy_cycles equals the cycle count from go to the done rise.
